// File: rtl/cistern_pump_ctrl.sv
// cistern_pump_ctrl: debounced floater decode, hysteresis fill FSM and fault supervision for the cistern pump
module cistern_pump_ctrl #(
  parameter int DEBOUNCE  = 4,
  parameter int LEVEL_ON  = 2,
  parameter int LEVEL_OFF = 8,
  parameter int MAX_RUN   = 1000,
  parameter int STALL     = 200,
  parameter int MIN_OFF   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] floater,
  input  logic       enable,
  input  logic       fault_clr,
  output logic       pump_on,
  output logic [3:0] level,
  output logic [1:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam int SW = $clog2(STALL + 1);
  localparam int OW = $clog2(MIN_OFF + 1);
  localparam logic [DW-1:0] CNT_END   = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] RUN_END   = RW'(MAX_RUN - 1);
  localparam logic [SW-1:0] STALL_END = SW'(STALL - 1);
  localparam logic [OW-1:0] OFF_END   = OW'(MIN_OFF - 1);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FILL = 2'b01, S_REST = 2'b10, S_FAULT = 2'b11} st_t;
  st_t st, st_n;
  logic [1:0] code_n;
  logic [3:0] ones, raw, cand, prev_level;
  logic [DW-1:0] cnt;
  logic [RW-1:0] run_t;
  logic [SW-1:0] stall_t;
  logic [OW-1:0] off_t;
  logic bad, inc;
  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'd0, floater[i]};
  end
  assign raw = ((floater & (floater + 8'd1)) == 8'd0) ? ones : 4'hE;
  assign bad = level == 4'hE;
  assign inc = !bad && prev_level != 4'hE && level > prev_level;
  assign state = st;
  assign fault = st == S_FAULT;
  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      cnt        <= '0;
      level      <= '0;
      prev_level <= '0;
    end else begin
      prev_level <= level;
      if (raw != cand) begin
        cand <= raw;
        cnt  <= '0;
      end else if (cnt != CNT_END) cnt <= cnt + DW'(1);
      else level <= cand;
    end
  end
  always_comb begin
    st_n   = st;
    code_n = fault_code;
    case (st)
      S_IDLE:
        if (bad) {st_n, code_n} = {S_FAULT, 2'b01};
        else if (enable && level <= 4'(LEVEL_ON)) st_n = S_FILL;
      S_FILL:
        if (bad) {st_n, code_n} = {S_FAULT, 2'b01};
        else if (level >= 4'(LEVEL_OFF) || !enable) st_n = S_REST;
        else if (stall_t == STALL_END) {st_n, code_n} = {S_FAULT, 2'b10};
        else if (run_t == RUN_END) {st_n, code_n} = {S_FAULT, 2'b11};
      S_REST:
        if (bad) {st_n, code_n} = {S_FAULT, 2'b01};
        else if (off_t == OFF_END) st_n = S_IDLE;
      default:
        if (fault_clr && !bad) {st_n, code_n} = {S_IDLE, 2'b00};
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      fault_code <= '0;
      pump_on    <= 1'b0;
      run_t      <= '0;
      stall_t    <= '0;
      off_t      <= '0;
    end else begin
      st         <= st_n;
      fault_code <= code_n;
      pump_on    <= st_n == S_FILL;
      run_t      <= st == S_FILL ? run_t + RW'(run_t != RUN_END) : '0;
      stall_t    <= st == S_FILL ? (inc ? '0 : stall_t + SW'(stall_t != STALL_END)) : '0;
      off_t      <= st == S_REST ? off_t + OW'(off_t != OFF_END) : '0;
    end
  end
endmodule

// File: tb/tb_cistern_pump_ctrl.sv
// tb_cistern_pump_ctrl: directed and randomized checks of the pump controller against a behavioural model
module tb_cistern_pump_ctrl;
  localparam int D    = 4;
  localparam int ON   = 2;
  localparam int OFF  = 8;
  localparam int MAXR = 40;
  localparam int STL  = 20;
  localparam int MOFF = 5;
  logic clk = 1'b0;
  logic rst, enable, fault_clr, pump_on, fault;
  logic [7:0] floater;
  logic [3:0] level;
  logic [1:0] state, fault_code;
  int n_chk = 0;
  int n_pass = 0;
  int m_st, m_code, m_level, m_prev, m_run, m_stall, m_off;
  int hist[$];
  cistern_pump_ctrl #(
    .DEBOUNCE(D), .LEVEL_ON(ON), .LEVEL_OFF(OFF), .MAX_RUN(MAXR), .STALL(STL), .MIN_OFF(MOFF)
  ) dut (
    .clk(clk), .rst(rst), .floater(floater), .enable(enable), .fault_clr(fault_clr),
    .pump_on(pump_on), .level(level), .state(state), .fault(fault), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  function automatic int decode(input logic [7:0] f);
    for (int n = 0; n <= 8; n++) if (int'(f) == (1 << n) - 1) return n;
    return 14;
  endfunction
  function automatic logic [7:0] therm(input int n);
    return 8'((1 << n) - 1);
  endfunction
  always @(posedge clk) begin : model
    int raw, nl;
    bit all_eq, bad, inc;
    if (rst) begin
      m_st = 0; m_code = 0; m_level = 0; m_prev = 0;
      m_run = 0; m_stall = 0; m_off = 0;
      hist = {0};
    end else begin
      raw = decode(floater);
      hist.push_back(raw);
      if (hist.size() > D + 1) void'(hist.pop_front());
      nl = m_level;
      if (hist.size() == D + 1) begin
        all_eq = 1'b1;
        foreach (hist[i]) if (hist[i] != raw) all_eq = 1'b0;
        if (all_eq) nl = raw;
      end
      bad = m_level == 14;
      inc = !bad && m_prev != 14 && m_level > m_prev;
      case (m_st)
        0: if (bad) begin m_st = 3; m_code = 1; end
           else if (enable && m_level <= ON) begin m_st = 1; m_run = 0; m_stall = 0; end
        1: begin
          if (bad) begin m_st = 3; m_code = 1; end
          else if (m_level >= OFF || !enable) begin m_st = 2; m_off = 0; end
          else if (m_stall == STL - 1) begin m_st = 3; m_code = 2; end
          else if (m_run == MAXR - 1) begin m_st = 3; m_code = 3; end
          m_run++;
          m_stall = inc ? 0 : m_stall + 1;
        end
        2: begin
          if (bad) begin m_st = 3; m_code = 1; end
          else if (m_off == MOFF - 1) m_st = 0;
          m_off++;
        end
        default: if (fault_clr && !bad) begin m_st = 0; m_code = 0; end
      endcase
      m_prev  = m_level;
      m_level = nl;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check("state", 32'(state), m_st);
    check("level", 32'(level), m_level);
    check("pump_on", 32'(pump_on), 32'(m_st == 1));
    check("fault", 32'(fault), 32'(m_st == 3));
    check("fault_code", 32'(fault_code), m_code);
  endtask
  task automatic hold(input logic [7:0] f, input int n);
    floater = f;
    repeat (n) tick();
  endtask
  initial begin
    rst = 1'b1; floater = 8'h00; enable = 1'b0; fault_clr = 1'b0;
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_pump", 32'(pump_on), 0);
    rst = 1'b0;
    hold(8'hFF, 8);
    check("idle_full", 32'(level), 8);
    enable = 1'b1;
    hold(8'h03, 4);
    check("deb_hold", 32'(level), 8);
    tick();
    check("deb_level", 32'(level), 2);
    check("deb_idle", 32'(state), 0);
    tick();
    check("fill_start", 32'(state), 1);
    check("fill_pump", 32'(pump_on), 1);
    hold(8'h07, 3);
    hold(8'h03, 5);
    check("glitch", 32'(level), 2);
    for (int n = 3; n <= 7; n++) hold(therm(n), 5);
    hold(8'hFF, 12);
    check("rest_idle", 32'(state), 0);
    check("rest_pump", 32'(pump_on), 0);
    hold(8'h01, 25);
    check("stall_pre", 32'(state), 1);
    tick();
    check("stall_state", 32'(state), 3);
    check("stall_code", 32'(fault_code), 2);
    check("stall_pump", 32'(pump_on), 0);
    fault_clr = 1'b1;
    tick();
    check("clr_idle", 32'(state), 0);
    fault_clr = 1'b0;
    tick();
    check("refill", 32'(state), 1);
    hold(8'h03, 15);
    hold(8'h07, 15);
    hold(8'h0F, 9);
    check("run_pre", 32'(state), 1);
    tick();
    check("run_state", 32'(state), 3);
    check("run_code", 32'(fault_code), 3);
    check("run_level", 32'(level), 4);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    hold(8'h03, 8);
    check("s5_fill", 32'(state), 1);
    hold(8'h05, 8);
    check("sens_state", 32'(state), 3);
    check("sens_code", 32'(fault_code), 1);
    check("sens_level", 32'(level), 14);
    fault_clr = 1'b1;
    tick();
    check("sens_hold", 32'(state), 3);
    check("sens_hold_code", 32'(fault_code), 1);
    fault_clr = 1'b0;
    hold(8'h07, 6);
    fault_clr = 1'b1;
    tick();
    check("sens_clr", 32'(state), 0);
    fault_clr = 1'b0;
    hold(8'h03, 8);
    check("s6_fill", 32'(state), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_pump", 32'(pump_on), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_code", 32'(fault_code), 0);
    rst = 1'b0;
    tick();
    check("post_rst_fill", 32'(state), 1);
    enable = 1'b0;
    tick();
    check("en_drop", 32'(state), 2);
    for (int k = 0; k < 250; k++) begin
      logic [7:0] f;
      int len;
      if ($urandom_range(0, 99) < 8) begin
        f = 8'($urandom);
        if (decode(f) != 14) f = 8'h05;
      end else f = therm($urandom_range(0, 8));
      enable = $urandom_range(0, 9) != 0;
      floater = f;
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        fault_clr = $urandom_range(0, 7) == 0;
        rst = $urandom_range(0, 399) == 0;
        tick();
      end
    end
    rst = 1'b0;
    fault_clr = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
